// File: rtl/mu0_pkg.sv
// -----------------------------------------------------------------------------
// mu0_pkg
// Shared definitions for the MU0 memory responder: word width, the
// memory-mapped register addresses and the responder FSM state encoding.
// -----------------------------------------------------------------------------
package mu0_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 12;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t CNT_ADDR = 12'hFFD;
  localparam addr_t LED_ADDR = 12'hFFE;
  localparam addr_t SW_ADDR  = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mu0_mem_responder_if.sv
// -----------------------------------------------------------------------------
// mu0_mem_responder_if
// MU0 memory request bus.
//   address  : 12-bit word address      (master -> slave)
//   data_out : 16-bit write data        (master -> slave)
//   rd / wr  : request, held until ready (master -> slave)
//   data_in  : 16-bit read data         (slave -> master)
//   ready    : one-cycle completion     (slave -> master)
// -----------------------------------------------------------------------------
interface mu0_mem_responder_if;
  import mu0_pkg::*;

  addr_t address;
  word_t data_out;
  logic  rd;
  logic  wr;
  word_t data_in;
  logic  ready;

  modport master (output address, data_out, rd, wr, input  data_in, ready);
  modport slave  (input  address, data_out, rd, wr, output data_in, ready);

endinterface

// File: rtl/mu0_ram.sv
// -----------------------------------------------------------------------------
// mu0_ram
// Single-port synchronous word RAM, 2**AW x 16, registered read.
//   i_clk   : clock
//   i_addr  : word address
//   i_we    : write enable
//   i_wdata : write data
//   o_rdata : read data, registered (old data on a write cycle)
// -----------------------------------------------------------------------------
module mu0_ram
  import mu0_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  word_t         i_wdata,
  output word_t         o_rdata
);

  word_t r_mem [2**AW];

  // NOTE: the array has no reset; clearing it would prevent mapping onto
  // block RAM, and its contents are deliberately preserved across Reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/mu0_mem_responder.sv
// -----------------------------------------------------------------------------
// mu0_mem_responder
// Memory-side responder for MU0. Each accepted request is held for
// WAIT_STATES cycles, then completed with a one-cycle ready strobe. Requests
// are served from a word RAM or from memory-mapped registers:
//   0xFFE LED (R/W), 0xFFF switches (R), 0xFFD cycle counter (optional).
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : MU0 request bus (slave side)
//   i_halted     : MU0 stopped; freezes the cycle counter
//   i_switches   : board switches
//   o_led        : LED register
//   o_err        : sticky error, set when rd and wr are requested together
// Build option: define MU0_MEM_CYCLE_COUNT_EN to map a 16-bit cycle counter at
// 0xFFD; otherwise that address is ordinary RAM.
// -----------------------------------------------------------------------------
module mu0_mem_responder
  import mu0_pkg::*;
#(
  parameter int MEM_AW      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mu0_mem_responder_if.slave    bus,
  input  logic                  i_halted,
  input  word_t                 i_switches,
  output word_t                 o_led,
  output logic                  o_err
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e     r_state;
  logic [3:0] r_wait;
  addr_t      r_addr;
  word_t      r_wdata;
  logic       r_is_wr;
  logic       r_ready;
  word_t      r_data_in;
  logic       r_ram_rd;
  word_t      r_led;
  logic       r_err;

  logic  w_req_one, w_req_any, w_req_both;
  addr_t w_addr;
  word_t w_wdata;
  logic  w_is_wr;
  logic  w_commit;
  logic  w_is_led, w_is_sw, w_is_cnt, w_is_ram;
  word_t w_cnt_val, w_reg_rd, w_ram_q;

  assign w_req_one  = bus.rd ^ bus.wr;
  assign w_req_any  = bus.rd | bus.wr;
  assign w_req_both = bus.rd & bus.wr;

  // With zero wait states the access commits on the same edge that accepts
  // it, so the live bus is used in IDLE and the latched request otherwise.
  assign w_addr  = (r_state == ST_IDLE) ? bus.address  : r_addr;
  assign w_wdata = (r_state == ST_IDLE) ? bus.data_out : r_wdata;
  assign w_is_wr = (r_state == ST_IDLE) ? bus.wr       : r_is_wr;

  // High on the edge that enters DONE: writes land and read data is captured.
  assign w_commit = ((r_state == ST_IDLE) && w_req_one && (WS == 4'd0)) ||
                    ((r_state == ST_WAIT) && w_req_any && (r_wait == 4'd1));

  assign w_is_led = (w_addr == LED_ADDR);
  assign w_is_sw  = (w_addr == SW_ADDR);
  assign w_is_ram = !(w_is_led || w_is_sw || w_is_cnt);
  assign w_reg_rd = w_is_led ? r_led : (w_is_sw ? i_switches : w_cnt_val);

`ifdef MU0_MEM_CYCLE_COUNT_EN
  word_t r_cycles;

  assign w_is_cnt  = (w_addr == CNT_ADDR);
  assign w_cnt_val = r_cycles;

  // A write to the counter wins over the free-running increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                               r_cycles <= '0;
    else if (w_commit && w_is_wr && w_is_cnt) r_cycles <= '0;
    else if (!i_halted)                      r_cycles <= r_cycles + 16'd1;
  end
`else
  logic w_unused_halted;

  assign w_is_cnt        = 1'b0;
  assign w_cnt_val       = '0;
  assign w_unused_halted = i_halted;
`endif

  mu0_ram #(.AW(MEM_AW)) u_ram (
    .i_clk   (i_clk),
    .i_addr  (w_addr[MEM_AW-1:0]),
    .i_we    (w_commit && w_is_wr && w_is_ram),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_q)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others, independent of order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_wait    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_is_wr   <= 1'b0;
      r_ready   <= 1'b0;
      r_data_in <= '0;
      r_ram_rd  <= 1'b0;
      r_led     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_ready <= 1'b0;

      // RAM read data arrives one cycle after the commit edge; fold it into
      // the holding register at the end of DONE.
      if (r_ram_rd) begin
        r_data_in <= w_ram_q;
        r_ram_rd  <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_req_both) begin
            r_err <= 1'b1;
          end else if (w_req_one) begin
            r_addr  <= bus.address;
            r_wdata <= bus.data_out;
            r_is_wr <= bus.wr;
            if (WS == 4'd0) begin
              r_state <= ST_DONE;
              r_ready <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
              r_wait  <= WS;
            end
          end
        end
        ST_WAIT: begin
          if (!w_req_any) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait - 4'd1;
            if (r_wait == 4'd1) begin
              r_state <= ST_DONE;
              r_ready <= 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_commit) begin
        if (w_is_wr) begin
          if (w_is_led) r_led <= w_wdata;
        end else if (w_is_ram) begin
          r_ram_rd <= 1'b1;
        end else begin
          r_data_in <= w_reg_rd;
        end
      end
    end
  end

  assign bus.data_in = r_ram_rd ? w_ram_q : r_data_in;
  assign bus.ready   = r_ready;
  assign o_led       = r_led;
  assign o_err       = r_err;

endmodule

// File: tb/tb_mu0_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mu0_mem_responder
// Two responders (WAIT_STATES=1 and WAIT_STATES=0, MEM_AW=8) driven through
// directed and random accesses, compared against a behavioural memory-map
// model. Define MU0_MEM_CYCLE_COUNT_EN to exercise the cycle counter.
// -----------------------------------------------------------------------------
module tb_mu0_mem_responder;
  import mu0_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  halted = 1'b1;
  word_t sw = '0;
  word_t led1, led0;
  logic  err1, err0;

  always #5 clk = ~clk;

  mu0_mem_responder_if bus1 ();
  mu0_mem_responder_if bus0 ();

  mu0_mem_responder #(.MEM_AW(8), .WAIT_STATES(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .bus(bus1), .i_halted(halted),
    .i_switches(sw), .o_led(led1), .o_err(err1)
  );

  mu0_mem_responder #(.MEM_AW(8), .WAIT_STATES(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .bus(bus0), .i_halted(halted),
    .i_switches(sw), .o_led(led0), .o_err(err0)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model, one copy per responder (index = its wait-state count).
  word_t m_mem  [2][256];
  word_t m_led  [2];
  bit    m_err  [2];
  word_t m_last [2];
  word_t m_cnt  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit cnt_en();
`ifdef MU0_MEM_CYCLE_COUNT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic get_ready(input int d);
    return (d == 1) ? bus1.ready : bus0.ready;
  endfunction
  function automatic word_t get_din(input int d);
    return (d == 1) ? bus1.data_in : bus0.data_in;
  endfunction
  function automatic word_t get_led(input int d);
    return (d == 1) ? led1 : led0;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 1) ? err1 : err0;
  endfunction

  task automatic drive(input int d, input logic rd, input logic wr, input addr_t a, input word_t dat);
    if (d == 1) begin
      bus1.rd = rd; bus1.wr = wr; bus1.address = a; bus1.data_out = dat;
    end else begin
      bus0.rd = rd; bus0.wr = wr; bus0.address = a; bus0.data_out = dat;
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_led[d] = '0; m_err[d] = 1'b0; m_last[d] = '0; m_cnt[d] = '0;
    end
  endfunction

  // One complete access: drive, wait for ready, check, release.
  task automatic access(input int d, input bit is_wr, input addr_t a, input word_t dat);
    int    lat = 0;
    int    idx = int'(a) % 256;
    word_t exp_rd = '0;
    if (is_wr) begin
      if (a == LED_ADDR)                  m_led[d] = dat;
      else if (a == SW_ADDR)              ;
      else if (cnt_en() && a == CNT_ADDR) m_cnt[d] = '0;
      else                                m_mem[d][idx] = dat;
    end else begin
      if (a == LED_ADDR)                  exp_rd = m_led[d];
      else if (a == SW_ADDR)              exp_rd = sw;
      else if (cnt_en() && a == CNT_ADDR) exp_rd = m_cnt[d];
      else                                exp_rd = m_mem[d][idx];
    end
    drive(d, !is_wr, is_wr, a, dat);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (get_ready(d)) begin
        lat = k;
        break;
      end
    end
    check($sformatf("latency d%0d a%03h", d, a), lat, d + 1);
    if (lat != 0) begin
      if (!is_wr) begin
        check($sformatf("rd_data d%0d a%03h", d, a), get_din(d), exp_rd);
        m_last[d] = exp_rd;
      end else begin
        check($sformatf("din_hold d%0d", d), get_din(d), m_last[d]);
      end
      check($sformatf("led d%0d", d), get_led(d), m_led[d]);
      check($sformatf("err d%0d", d), get_err(d), m_err[d]);
    end
    drive(d, 1'b0, 1'b0, a, dat);
    @(posedge clk); #1;
    check($sformatf("ready_pulse d%0d", d), get_ready(d), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    addr_t a;
    drive(1, 0, 0, '0, '0);
    drive(0, 0, 0, '0, '0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Reset state.
    check("rst_ready", bus1.ready, 1'b0);
    check("rst_din",   bus1.data_in, 16'h0);
    check("rst_led",   led1, 16'h0);
    check("rst_err",   err1, 1'b0);

    // Prefill both RAMs so every later read has a known expectation.
    for (int i = 0; i < 256; i++) begin
      access(1, 1'b1, addr_t'(i), word_t'($urandom));
      access(0, 1'b1, addr_t'(i), word_t'($urandom));
    end

    // Basic RAM write/read, one wait state.
    access(1, 1'b1, 12'h010, 16'h1234);
    access(1, 1'b0, 12'h010, 16'h0);

    // LED, switches, ignored write to switches.
    access(1, 1'b1, LED_ADDR, 16'h00A5);
    sw = 16'hBEEF;
    access(1, 1'b0, SW_ADDR, 16'h0);
    access(1, 1'b1, SW_ADDR, 16'h1111);

    // Aliasing modulo depth, and zero-wait-state responder.
    access(1, 1'b1, 12'h105, 16'h0F0F);
    access(1, 1'b0, 12'h005, 16'h0);
    access(0, 1'b1, 12'h2A7, 16'hC3C3);
    access(0, 1'b0, 12'h0A7, 16'h0);

    // Rd and Wr together: no ready, sticky error.
    drive(1, 1'b1, 1'b1, 12'h050, 16'h0);
    m_err[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("both_no_ready", bus1.ready, 1'b0);
    end
    check("both_err", err1, 1'b1);
    drive(1, 1'b0, 1'b0, 12'h050, 16'h0);

    // Write dropped during WAIT: aborted, RAM untouched.
    drive(1, 1'b0, 1'b1, 12'h030, 16'hAAAA);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 12'h030, 16'hAAAA);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_no_ready", bus1.ready, 1'b0);
    end
    access(1, 1'b0, 12'h030, 16'h0);
    check("err_sticky", err1, 1'b1);

    // Random traffic over both responders.
    for (int n = 0; n < 80; n++) begin
      int d = int'($urandom_range(0, 1));
      int r = int'($urandom_range(0, 9));
      if (r == 0)      a = LED_ADDR;
      else if (r == 1) a = SW_ADDR;
      else if (r == 2) a = CNT_ADDR;
      else             a = addr_t'($urandom_range(0, 12'hFFC));
      sw = word_t'($urandom);
      access(d, 1'($urandom_range(0, 1)), a, word_t'($urandom));
    end

    // Reset in the middle of WAIT: outputs clear at once, no write lands.
    drive(1, 1'b0, 1'b1, 12'h040, 16'h5555);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_ready", bus1.ready, 1'b0);
    check("midrst_din",   bus1.data_in, 16'h0);
    check("midrst_led",   led1, 16'h0);
    check("midrst_err",   err1, 1'b0);
    drive(1, 1'b0, 1'b0, 12'h040, 16'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("postrst_ready", bus1.ready, 1'b0);
    access(1, 1'b0, 12'h040, 16'h0);

    // Cycle counter: ten running cycles, read, clear, read.
    halted = 1'b0;
    repeat (10) @(posedge clk);
    #1 halted = 1'b1;
    if (cnt_en()) begin
      m_cnt[0] = m_cnt[0] + 16'd10;
      m_cnt[1] = m_cnt[1] + 16'd10;
    end
    access(1, 1'b0, CNT_ADDR, 16'h0);
    access(1, 1'b1, CNT_ADDR, 16'h7777);
    access(1, 1'b0, CNT_ADDR, 16'h0);
    access(0, 1'b0, CNT_ADDR, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
